// File: rtl/gpio_pad_ctrl.sv
// GPIO pad controller: N bidirectional pins with synchronised, glitch-filtered inputs,
// edge/level interrupt capture and a single-cycle register bus.
`timescale 1ns/1ps
module gpio_pad_ctrl #(
  parameter int N             = 16,
  parameter int FILTER_CYCLES = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req,
  input  logic          we,
  input  logic [2:0]    addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata,
  output logic          rvalid,
  input  logic [N-1:0]  gpio_i,
  output logic [N-1:0]  gpio_o,
  output logic [N-1:0]  gpio_oe_n,
  input  logic          test_en,
  output logic          irq
);

  localparam int CW = (FILTER_CYCLES > 0) ? $clog2(FILTER_CYCLES + 1) : 1;

  logic [N-1:0]   r_sync1;
  logic [N-1:0]   r_sync2;
  logic [N-1:0]   r_filt_d;
  logic [N-1:0]   r_dout;
  logic [N-1:0]   r_oe;
  logic [N-1:0]   r_irq_en;
  logic [2*N-1:0] r_mode;
  logic [N-1:0]   r_pend;
  logic [31:0]    r_rdata;
  logic           r_rvalid;
  logic           r_irq;

  logic [N-1:0]   w_filt;
  logic [N-1:0]   w_set;
  logic [N-1:0]   w_clr;
  logic [31:0]    w_rmux;
  logic           w_wr;

  generate
    if (FILTER_CYCLES > 0) begin : g_filt
      localparam logic [CW-1:0] CMAX = CW'(FILTER_CYCLES - 1);
      logic [N-1:0]  r_filt;
      logic [CW-1:0] r_cnt [N];

      // A mismatch must persist FILTER_CYCLES consecutive cycles before it is accepted.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_filt <= '0;
          for (int i = 0; i < N; i++) r_cnt[i] <= '0;
        end else begin
          for (int i = 0; i < N; i++) begin
            if (r_sync2[i] == r_filt[i]) begin
              r_cnt[i] <= '0;
            end else if (r_cnt[i] == CMAX) begin
              r_filt[i] <= r_sync2[i];
              r_cnt[i]  <= '0;
            end else begin
              r_cnt[i] <= r_cnt[i] + 1'b1;
            end
          end
        end
      end
      assign w_filt = r_filt;
    end else begin : g_nofilt
      assign w_filt = r_sync2;
    end
  endgenerate

  assign w_wr  = req & we;
  assign w_clr = (w_wr && addr == 3'd5) ? wdata[N-1:0] : '0;

  always_comb begin
    w_set = '0;
    for (int i = 0; i < N; i++) begin
      case (r_mode[2*i +: 2])
        2'b00:   w_set[i] = w_filt[i] & ~r_filt_d[i];
        2'b01:   w_set[i] = ~w_filt[i] & r_filt_d[i];
        2'b10:   w_set[i] = w_filt[i] ^ r_filt_d[i];
        default: w_set[i] = w_filt[i];
      endcase
    end
  end

  always_comb begin
    w_rmux = '0;
    case (addr)
      3'd0:    w_rmux = 32'(w_filt);
      3'd1:    w_rmux = 32'(r_dout);
      3'd2:    w_rmux = 32'(r_oe);
      3'd3:    w_rmux = 32'(r_irq_en);
      3'd4:    w_rmux = 32'(r_mode);
      3'd5:    w_rmux = 32'(r_pend);
      default: w_rmux = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1  <= '0;
      r_sync2  <= '0;
      r_filt_d <= '0;
      r_dout   <= '0;
      r_oe     <= '0;
      r_irq_en <= '0;
      r_mode   <= '0;
      r_pend   <= '0;
      r_rdata  <= '0;
      r_rvalid <= 1'b0;
      r_irq    <= 1'b0;
    end else begin
      r_sync1  <= gpio_i;
      r_sync2  <= r_sync1;
      r_filt_d <= w_filt;
      if (w_wr && addr == 3'd1) r_dout   <= wdata[N-1:0];
      if (w_wr && addr == 3'd2) r_oe     <= wdata[N-1:0];
      if (w_wr && addr == 3'd3) r_irq_en <= wdata[N-1:0];
      if (w_wr && addr == 3'd4) r_mode   <= wdata[2*N-1:0];
      // Set is ORed in after the clear so a coincident event is never lost.
      r_pend   <= (r_pend & ~w_clr) | w_set;
      r_irq    <= |(r_pend & r_irq_en);
      r_rvalid <= req;
      r_rdata  <= req ? w_rmux : '0;
    end
  end

  assign gpio_o    = test_en ? '0 : r_dout;
  assign gpio_oe_n = test_en ? '1 : ~r_oe;
  assign rdata     = r_rdata;
  assign rvalid    = r_rvalid;
  assign irq       = r_irq;

endmodule

// File: tb/tb_gpio_pad_ctrl.sv
// Scoreboard bench for gpio_pad_ctrl: bus requests queue their expected read data,
// a negedge monitor pops and compares on every rvalid.
`timescale 1ns/1ps
module tb_gpio_pad_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req = 1'b0;
  logic        we = 1'b0;
  logic [2:0]  addr = '0;
  logic [31:0] wdata = '0;
  logic [31:0] rdata;
  logic        rvalid;
  logic [15:0] gpio_i = '0;
  logic [15:0] gpio_o;
  logic [15:0] gpio_oe_n;
  logic        test_en = 1'b0;
  logic        irq;

  int total = 0;
  int bad = 0;

  logic [31:0] q_exp [$];
  bit          q_chk [$];
  string       q_name [$];

  always #5 clk = ~clk;

  gpio_pad_ctrl #(.N(16), .FILTER_CYCLES(4)) dut (
    .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .rdata(rdata), .rvalid(rvalid), .gpio_i(gpio_i), .gpio_o(gpio_o),
    .gpio_oe_n(gpio_oe_n), .test_en(test_en), .irq(irq)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic bus(input logic w, input logic [2:0] a, input logic [31:0] d,
                     input logic [31:0] exp, input string name);
    req = 1'b1; we = w; addr = a; wdata = d;
    q_exp.push_back(exp);
    q_chk.push_back(!w);
    q_name.push_back(name);
    @(negedge clk);
    req = 1'b0; we = 1'b0;
  endtask

  task automatic rd(input logic [2:0] a, input logic [31:0] exp, input string name);
    bus(1'b0, a, 32'h0, exp, name);
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    bus(1'b1, a, d, 32'h0, "write");
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (rvalid === 1'b1) begin
      total++;
      if (q_exp.size() == 0) begin
        bad++;
        $display("FAIL unexpected_rvalid: got rdata 0x%08h expected no response", rdata);
      end else begin
        logic [31:0] e;
        bit          c;
        string       nm;
        e  = q_exp.pop_front();
        c  = q_chk.pop_front();
        nm = q_name.pop_front();
        if (c && rdata !== e) begin
          bad++;
          $display("FAIL %s: got 0x%08h expected 0x%08h", nm, rdata, e);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not reach the end");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset with pads low
    idle(2);
    check("rst_gpio_o", 32'(gpio_o), 32'h0);
    check("rst_oe_n", 32'(gpio_oe_n), 32'hFFFF);
    check("rst_irq", 32'(irq), 32'h0);
    check("rst_rvalid", 32'(rvalid), 32'h0);
    check("rst_rdata", rdata, 32'h0);
    rst = 1'b0;
    idle(2);
    for (int a = 0; a < 8; a++) rd(3'(a), 32'h0, "reset_read");
    check("post_rst_oe_n", 32'(gpio_oe_n), 32'hFFFF);
    check("post_rst_irq", 32'(irq), 32'h0);

    // Output drive and test-mode override
    wr(3'd2, 32'h0000_00FF);
    wr(3'd1, 32'hFFFF_A5A5);
    check("drive_gpio_o", 32'(gpio_o), 32'hA5A5);
    check("drive_oe_n", 32'(gpio_oe_n), 32'hFF00);
    test_en = 1'b1;
    #1;
    check("test_gpio_o", 32'(gpio_o), 32'h0);
    check("test_oe_n", 32'(gpio_oe_n), 32'hFFFF);
    test_en = 1'b0;
    #1;
    check("restore_gpio_o", 32'(gpio_o), 32'hA5A5);
    check("restore_oe_n", 32'(gpio_oe_n), 32'hFF00);
    @(negedge clk);
    rd(3'd1, 32'h0000_A5A5, "dout_masked");
    rd(3'd2, 32'h0000_00FF, "oe_read");
    wr(3'd6, 32'hFFFF_FFFF);
    rd(3'd6, 32'h0, "addr6_zero");
    rd(3'd7, 32'h0, "addr7_zero");
    wr(3'd3, 32'hFFFF_1234);
    rd(3'd3, 32'h0000_1234, "wr_then_rd");
    wr(3'd3, 32'h0);

    // Glitch filter: 3-cycle pulse rejected
    gpio_i[3] = 1'b1;
    idle(3);
    gpio_i[3] = 1'b0;
    idle(10);
    rd(3'd0, 32'h0, "short_pulse_din");
    rd(3'd5, 32'h0, "short_pulse_pend");

    // 4-cycle pulse: DATA_IN[3] seen from the 7th per-cycle read onward
    for (int k = 1; k <= 8; k++) begin
      if (k == 1) gpio_i[3] = 1'b1;
      if (k == 5) gpio_i[3] = 1'b0;
      rd(3'd0, (k >= 7) ? 32'h8 : 32'h0, "filter_latency");
    end
    idle(10);
    rd(3'd0, 32'h0, "pulse_gone");
    rd(3'd5, 32'h8, "rise_pending");
    wr(3'd5, 32'h8);
    rd(3'd5, 32'h0, "rise_cleared");
    check("irq_masked", 32'(irq), 32'h0);

    // Falling-edge interrupt on pin 2
    wr(3'd4, 32'h10);
    gpio_i[2] = 1'b1;
    idle(10);
    rd(3'd0, 32'h4, "din_pin2");
    wr(3'd5, 32'hFFFF);
    rd(3'd5, 32'h0, "pend_cleared");
    wr(3'd3, 32'h4);
    idle(2);
    check("irq_idle", 32'(irq), 32'h0);
    gpio_i[2] = 1'b0;
    idle(7);
    check("irq_before", 32'(irq), 32'h0);
    idle(1);
    check("irq_fall", 32'(irq), 32'h1);
    rd(3'd5, 32'h4, "fall_pending");
    wr(3'd5, 32'h4);
    check("irq_hold", 32'(irq), 32'h1);
    idle(1);
    check("irq_cleared", 32'(irq), 32'h0);
    rd(3'd5, 32'h0, "fall_pend_cleared");

    // Level mode on pin 0: set beats a coincident clear
    wr(3'd4, 32'h13);
    gpio_i[0] = 1'b1;
    idle(10);
    wr(3'd5, 32'h1);
    rd(3'd5, 32'h1, "level_set_wins");
    gpio_i[0] = 1'b0;
    idle(10);
    rd(3'd5, 32'h1, "level_sticky");
    wr(3'd5, 32'h1);
    rd(3'd5, 32'h0, "level_cleared");
    check("level_irq_masked", 32'(irq), 32'h0);

    // Reset mid filter count and mid read
    gpio_i[5] = 1'b1;
    idle(3);
    req = 1'b1; we = 1'b0; addr = 3'd1;
    #2 rst = 1'b1;
    #1;
    check("midrst_gpio_o", 32'(gpio_o), 32'h0);
    check("midrst_oe_n", 32'(gpio_oe_n), 32'hFFFF);
    check("midrst_irq", 32'(irq), 32'h0);
    check("midrst_rvalid", 32'(rvalid), 32'h0);
    check("midrst_rdata", rdata, 32'h0);
    @(negedge clk);
    req = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      check("no_rvalid_after_rst", 32'(rvalid), 32'h0);
      @(negedge clk);
    end
    rd(3'd2, 32'h0, "oe_after_rst");
    rd(3'd1, 32'h0, "dout_after_rst");
    rd(3'd0, 32'h0, "din_restart");
    idle(8);
    rd(3'd0, 32'h20, "din_refiltered");
    check("oe_n_after_rst", 32'(gpio_oe_n), 32'hFFFF);

    idle(3);
    check("scoreboard_empty", 32'(q_exp.size()), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/gpio_pad_ctrl.md
# gpio_pad_ctrl

Parametrised GPIO pad controller between the SoC bus and a row of bidirectional GPIO pad cells (pad-side `gpio_i` / `gpio_o` / `gpio_oe_n`). It generalises the fixed 16-pin pad hookup to N pins and adds the following per-pin features:
- input synchronisation;
- optional glitch filter;
- edge/level interrupt detection with sticky pending bits;
- a test-mode output override.

Software access is through a simple single-cycle request bus with registered read data.

## Interface
Parameters:
- `N`, 16, number of GPIO pins; legal range 1..16.
- `FILTER_CYCLES`, 4, glitch-filter length in cycles; 0 bypasses the filter.

Ports:
- `clk`  in  1  system clock; single clock domain.
- `rst`  in  1  asynchronous, active-high reset.
- `req`  in  1  bus request, one cycle per access; always accepted.
- `we`  in  1  1 = write, 0 = read.
- `addr`  in  3  word index of the register.
- `wdata`  in  32  write data.
- `rdata`  out  32  read data; valid when `rvalid` is high.
- `rvalid`  out  1  pulses one cycle after every `req` (reads and writes).
- `gpio_i`  in  N  raw pad input; asynchronous.
- `gpio_o`  out  N  pad output value.
- `gpio_oe_n`  out  N  pad output enable, active low.
- `test_en`  in  1  test mode; forces all pads to input.
- `irq`  out  1  OR of enabled pending bits.

## Operation
Register map (by `addr`). Bits at or above N read 0 and ignore writes.
- 0 DATA_IN: RO; filtered input value.
- 1 DATA_OUT: RW.
- 2 OE: RW; 1 = drive pin.
- 3 IRQ_EN: RW.
- 4 IRQ_MODE: RW; 2 bits per pin, `[2i+1:2i]`.
  - 00 rising edge.
  - 01 falling edge.
  - 10 both edges.
  - 11 level-high.
- 5 IRQ_PENDING: RW1C.
- 6–7: read 0; writes ignored.

Pad driving:
- Normal mode: `gpio_o = DATA_OUT`, `gpio_oe_n = ~OE`.
- `test_en=1`: `gpio_o = 0`, `gpio_oe_n = all 1`. Registers are not modified, and the normal values return the cycle `test_en` drops.

Input path, per pin:
- 2-flop synchroniser produces `sync`.
- Glitch filter (when FILTER_CYCLES > 0):
  - `cnt` clears whenever `sync == filt`.
  - Otherwise `cnt` increments each cycle.
  - When `cnt == FILTER_CYCLES-1` and a mismatch is still present, `filt <= sync` and `cnt <= 0`.
  - A mismatch shorter than FILTER_CYCLES cycles never reaches `filt`.
  - `cnt` width is `$clog2(FILTER_CYCLES+1)`.
- FILTER_CYCLES = 0: `filt` is a direct copy of `sync` (no register).
- Edge detect compares `filt` against `filt_d` (`filt` delayed one cycle).

Pending logic:
- Set conditions:
  - rise: `filt & ~filt_d`.
  - fall: `~filt & filt_d`.
  - both: either edge.
  - level: `filt` high, set every cycle.
- Pending bits set regardless of IRQ_EN. IRQ_EN only masks `irq`.
- A W1C write clears the selected bits. If a set event and a clear of the same bit occur in the same cycle, the set wins.
- `irq = |(IRQ_PENDING & IRQ_EN)`, registered.

Reset behaviour:
- All registers, synchroniser flops, `filt`, `filt_d` and `cnt` reset to 0.
- Output reset values: `gpio_o=0`, `gpio_oe_n=all 1`, `rdata=0`, `rvalid=0`, `irq=0`.
- Pins held high at reset release produce a rising-edge pending bit. Software clears IRQ_PENDING before setting IRQ_EN.
- Reset asserted mid-operation aborts any filter count. A read in flight returns no `rvalid`.

## Timing
Bus:
- `req` at cycle t gives `rvalid` at t+1.
- `rdata` at t+1 holds the register value sampled at t.
- A write updates the register at the edge ending cycle t, so the new value is visible on pads at t+1.
- Back-to-back requests every cycle are supported. Write-then-read of the same address returns the new value.

Input latency, pad change to DATA_IN:
- 2 cycles with FILTER_CYCLES = 0.
- 2 + FILTER_CYCLES cycles otherwise.

Interrupt latency:
- Pending is set 1 cycle after `filt` changes.
- `irq` asserts 1 cycle after pending is set.

`rdata` is 0 whenever `rvalid` is low.

## Test plan
- Reset with pads low; read all 8 addresses → all 0, `gpio_oe_n=0xFFFF`, `irq=0`.
- Write OE=0x00FF and DATA_OUT=0xA5A5 → next cycle `gpio_o=0xA5A5`, `gpio_oe_n=0xFF00`. Raise `test_en` → `gpio_oe_n=0xFFFF`, `gpio_o=0`. Drop it → previous values restored.
- FILTER_CYCLES=4, 3-cycle high pulse on `gpio_i[3]` → DATA_IN stays 0, no pending. 4-cycle pulse → DATA_IN[3] rises exactly 6 cycles after the pad edge.
- Pin 2 in mode 01 with IRQ_EN[2]=1, pad falls → IRQ_PENDING=0x4 and `irq=1` at the stated latency. Write 0x4 to IRQ_PENDING → `irq=0` two cycles later.
- Pin 0 in level mode held high, W1C of bit 0 in the same cycle as a set → bit stays 1. Drive the pin low, then W1C → bit clears.
- Assert `rst` mid-filter count and mid-read → all outputs return to reset values immediately, with no `rvalid` after release.
